// File: rtl/id_scoreboard.sv
// Pending-writer scoreboard for ID: per-register writer counts and load-busy flags drive stall/pending/back-pressure.
// Optional macro SCOREBOARD_STATS_EN adds a 32-bit stall cycle counter (stall_cnt_o).
module id_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int IDX_W   = 5,
  parameter int CNT_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid_i,
  input  logic             issue_rd_wen_i,
  input  logic             issue_is_load_i,
  input  logic [IDX_W-1:0] issue_rd_index_i,
  output logic             issue_ready_o,
  input  logic             load_data_valid_i,
  input  logic [IDX_W-1:0] load_data_index_i,
  input  logic             retire_valid_i,
  input  logic [IDX_W-1:0] retire_index_i,
  input  logic             flush_i,
  input  logic [IDX_W-1:0] id_rs1_index_i,
  input  logic [IDX_W-1:0] id_rs2_index_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  output logic             id_stall_o,
  output logic             rs1_pending_o,
  output logic             rs2_pending_o
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]      stall_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   cnt [1:REG_NUM-1];
  logic [REG_NUM-1:1] ld_busy;

  logic               rd_nz;
  logic               rd_at_max;
  logic               rd_retiring;
  logic               issue_acc;
  logic               rs1_nz_cnt, rs2_nz_cnt, rs1_ld, rs2_ld;
  logic [REG_NUM-1:1] inc_vec, dec_vec, ldclr_vec;

  assign rd_nz       = (issue_rd_index_i != '0);
  assign rd_retiring = retire_valid_i && (retire_index_i == issue_rd_index_i);

  always_comb begin
    rd_at_max  = 1'b0;
    rs1_nz_cnt = 1'b0;
    rs2_nz_cnt = 1'b0;
    rs1_ld     = 1'b0;
    rs2_ld     = 1'b0;
    for (int r = 1; r < REG_NUM; r++) begin
      if (issue_rd_index_i == IDX_W'(r)) rd_at_max = (cnt[r] == CNT_MAX);
      if (id_rs1_index_i == IDX_W'(r)) begin
        rs1_nz_cnt = (cnt[r] != '0);
        rs1_ld     = ld_busy[r];
      end
      if (id_rs2_index_i == IDX_W'(r)) begin
        rs2_nz_cnt = (cnt[r] != '0);
        rs2_ld     = ld_busy[r];
      end
    end
  end

  // A same-cycle retire to rd frees a slot, so a full counter can still accept.
  assign issue_ready_o = ~(issue_valid_i & issue_rd_wen_i & rd_nz & rd_at_max & ~rd_retiring);
  assign issue_acc     = issue_valid_i & issue_rd_wen_i & issue_ready_o & rd_nz;

  always_comb begin
    inc_vec   = '0;
    dec_vec   = '0;
    ldclr_vec = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      inc_vec[r]   = issue_acc && (issue_rd_index_i == IDX_W'(r));
      dec_vec[r]   = retire_valid_i && (retire_index_i == IDX_W'(r));
      ldclr_vec[r] = load_data_valid_i && (load_data_index_i == IDX_W'(r));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < REG_NUM; r++) cnt[r] <= '0;
      ld_busy <= '0;
    end else if (flush_i) begin
      for (int r = 1; r < REG_NUM; r++) cnt[r] <= '0;
      ld_busy <= '0;
    end else begin
      for (int r = 1; r < REG_NUM; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - CNT_W'(1);
        // Youngest writer decides forwardability, so issue beats load-data.
        if (inc_vec[r])
          ld_busy[r] <= issue_is_load_i;
        else if (ldclr_vec[r])
          ld_busy[r] <= 1'b0;
      end
    end
  end

  assign rs1_pending_o = (id_rs1_index_i != '0) & rs1_nz_cnt;
  assign rs2_pending_o = (id_rs2_index_i != '0) & rs2_nz_cnt;
  assign id_stall_o    = (id_rs1_used_i & (id_rs1_index_i != '0) & rs1_ld) |
                         (id_rs2_used_i & (id_rs2_index_i != '0) & rs2_ld);

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_o <= '0;
    else if (id_stall_o)
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed self-checking bench for id_scoreboard; inputs change 1ns after posedge, outputs checked before next posedge.
module tb_id_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid_i, issue_rd_wen_i, issue_is_load_i;
  logic [4:0] issue_rd_index_i;
  logic       issue_ready_o;
  logic       load_data_valid_i;
  logic [4:0] load_data_index_i;
  logic       retire_valid_i;
  logic [4:0] retire_index_i;
  logic       flush_i;
  logic [4:0] id_rs1_index_i, id_rs2_index_i;
  logic       id_rs1_used_i, id_rs2_used_i;
  logic       id_stall_o, rs1_pending_o, rs2_pending_o;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_scoreboard dut (
    .clk               (clk),
    .rst               (rst),
    .issue_valid_i     (issue_valid_i),
    .issue_rd_wen_i    (issue_rd_wen_i),
    .issue_is_load_i   (issue_is_load_i),
    .issue_rd_index_i  (issue_rd_index_i),
    .issue_ready_o     (issue_ready_o),
    .load_data_valid_i (load_data_valid_i),
    .load_data_index_i (load_data_index_i),
    .retire_valid_i    (retire_valid_i),
    .retire_index_i    (retire_index_i),
    .flush_i           (flush_i),
    .id_rs1_index_i    (id_rs1_index_i),
    .id_rs2_index_i    (id_rs2_index_i),
    .id_rs1_used_i     (id_rs1_used_i),
    .id_rs2_used_i     (id_rs2_used_i),
    .id_stall_o        (id_stall_o),
    .rs1_pending_o     (rs1_pending_o),
    .rs2_pending_o     (rs2_pending_o)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cnt_o       (stall_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid_i = 0; issue_rd_wen_i = 0; issue_is_load_i = 0; issue_rd_index_i = 0;
    load_data_valid_i = 0; load_data_index_i = 0;
    retire_valid_i = 0; retire_index_i = 0; flush_i = 0;
    id_rs1_index_i = 0; id_rs2_index_i = 0; id_rs1_used_i = 0; id_rs2_used_i = 0;
  endtask

  task automatic set_issue(input logic [4:0] rd, input logic is_load);
    issue_valid_i = 1; issue_rd_wen_i = 1; issue_is_load_i = is_load; issue_rd_index_i = rd;
  endtask

  task automatic set_retire(input logic [4:0] idx);
    retire_valid_i = 1; retire_index_i = idx;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;

    // Reset state
    check("rst_ready", issue_ready_o, 1);
    check("rst_stall", id_stall_o, 0);
    check("rst_pend1", rs1_pending_o, 0);
    check("rst_pend2", rs2_pending_o, 0);
    id_rs1_index_i = 5; id_rs1_used_i = 1; #1;
    check("idle_rs1_5_stall", id_stall_o, 0);
    check("idle_rs1_5_pend", rs1_pending_o, 0);
`ifdef SCOREBOARD_STATS_EN
    check("rst_stat", stall_cnt_o, 0);
`endif

    // Load rd=5: stall until load data, pending until retire
    idle(); set_issue(5, 1); tick();
    idle(); id_rs1_index_i = 5; id_rs1_used_i = 1; #1;
    check("ld5_stall", id_stall_o, 1);
    check("ld5_pend", rs1_pending_o, 1);
    load_data_valid_i = 1; load_data_index_i = 5; #1;
    check("ld5_stall_same_cycle", id_stall_o, 1);
    tick();                                   // stall edge #1
    load_data_valid_i = 0; #1;
    check("ld5_stall_dropped", id_stall_o, 0);
    check("ld5_pend_held", rs1_pending_o, 1);
    set_retire(5); tick();
    retire_valid_i = 0; #1;
    check("ld5_pend_retired", rs1_pending_o, 0);

    // Counter saturation on rd=7
    idle(); set_issue(7, 0);
    tick(); tick(); #1;
    check("rd7_ready_cnt2", issue_ready_o, 1);
    tick(); #1;
    check("rd7_ready_full", issue_ready_o, 0);
    id_rs1_index_i = 7; id_rs1_used_i = 1; #1;
    check("rd7_pend", rs1_pending_o, 1);
    check("rd7_alu_no_stall", id_stall_o, 0);
    set_retire(7); #1;
    check("rd7_ready_with_retire", issue_ready_o, 1);
    tick();
    retire_valid_i = 0; #1;
    check("rd7_still_full", issue_ready_o, 0);
    issue_valid_i = 0; set_retire(7);
    tick(); tick(); #1;
    check("rd7_pend_cnt1", rs1_pending_o, 1);
    tick();
    retire_valid_i = 0; #1;
    check("rd7_pend_drained", rs1_pending_o, 0);

    // Load then ALU on rd=9: youngest writer is forwardable
    idle(); set_issue(9, 1); tick();
    set_issue(9, 0); id_rs2_index_i = 9; id_rs2_used_i = 1; #1;
    check("rd9_load_stall", id_stall_o, 1);
    tick();                                   // stall edge #2
    issue_valid_i = 0; #1;
    check("rd9_alu_no_stall", id_stall_o, 0);
    check("rd9_pend", rs2_pending_o, 1);
    set_retire(9); tick(); #1;
    check("rd9_pend_cnt1", rs2_pending_o, 1);
    tick();
    retire_valid_i = 0; #1;
    check("rd9_pend_cnt0", rs2_pending_o, 0);

    // x0 ignored, retire on zero count saturates
    idle(); set_issue(0, 1); set_retire(0);
    id_rs1_index_i = 0; id_rs1_used_i = 1; id_rs2_index_i = 0; id_rs2_used_i = 1; #1;
    check("x0_ready", issue_ready_o, 1);
    tick();
    idle(); id_rs1_index_i = 0; id_rs1_used_i = 1; id_rs2_index_i = 0; id_rs2_used_i = 1; #1;
    check("x0_stall", id_stall_o, 0);
    check("x0_pend1", rs1_pending_o, 0);
    check("x0_pend2", rs2_pending_o, 0);
    idle(); set_retire(3); tick();
    idle(); set_issue(3, 0); tick();
    idle(); id_rs1_index_i = 3; #1;
    check("r3_pend_one", rs1_pending_o, 1);
    set_retire(3); tick();
    retire_valid_i = 0; #1;
    check("r3_no_wrap", rs1_pending_o, 0);

    // Same-cycle issue and load-data on rd=11: issue wins
    idle(); set_issue(11, 1); load_data_valid_i = 1; load_data_index_i = 11; tick();
    idle(); id_rs1_index_i = 11; id_rs1_used_i = 1; #1;
    check("rd11_issue_wins", id_stall_o, 1);
    load_data_valid_i = 1; load_data_index_i = 11;
    tick();                                   // stall edge #3
    load_data_valid_i = 0; #1;
    check("rd11_cleared", id_stall_o, 0);
    set_retire(11); tick();
`ifdef SCOREBOARD_STATS_EN
    check("stat_3", stall_cnt_o, 3);
`endif

    // Flush with same-cycle issue
    idle(); set_issue(4, 1); tick();
    set_issue(6, 0); tick(); tick();
    idle(); id_rs1_index_i = 4; id_rs1_used_i = 1; id_rs2_index_i = 6; id_rs2_used_i = 1; #1;
    check("pre_flush_stall", id_stall_o, 1);
    check("pre_flush_pend6", rs2_pending_o, 1);
    flush_i = 1; set_issue(6, 0); #1;
    check("flush_ready", issue_ready_o, 1);
    tick();                                   // stall edge #4
    flush_i = 0; issue_valid_i = 0; #1;
    check("post_flush_stall", id_stall_o, 0);
    check("post_flush_pend4", rs1_pending_o, 0);
    check("post_flush_pend6", rs2_pending_o, 0);
`ifdef SCOREBOARD_STATS_EN
    check("stat_flush_kept", stall_cnt_o, 4);
`endif

    // Asynchronous reset mid-operation
    idle(); set_issue(8, 1); tick();
    idle(); id_rs1_index_i = 8; id_rs1_used_i = 1; #1;
    check("pre_rst_stall", id_stall_o, 1);
    rst = 1; #1;
    check("async_rst_stall", id_stall_o, 0);
    check("async_rst_pend", rs1_pending_o, 0);
`ifdef SCOREBOARD_STATS_EN
    check("async_rst_stat", stall_cnt_o, 0);
`endif
    tick();
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
